// File: rtl/pipeline_fwd_chain.sv
// -----------------------------------------------------------------------------
// pipeline_fwd_chain
//
// Purpose
//   Parametrised in-flight instruction chain for the MIPS32 pipeline. It
//   replaces the hand-coded EX/MEM/WB destination/result registers and the
//   fixed ASrc/BSrc bypass muxes.
//
//   The module tracks DEPTH stages of {valid, we, rw, rdy, data}:
//     - Stage 0 is EX (youngest).
//     - Stage DEPTH-1 is WB (oldest).
//   It resolves forwarding for NUM_SRC source operands and flags a load-use
//   stall when the youngest matching producer has not produced its data yet.
//
// Parameters
//   DATA_W   result/data width
//   REG_W    register address width
//   DEPTH    number of tracked stages (legal range 2..8)
//   NUM_SRC  number of forwarding query ports
//
// Configuration macro
//   PIPE_FWD_CHAIN_WB_FWD_EN
//     Defined:   the WB stage is searched by forwarding. Use this with a
//                read-before-write register file.
//     Undefined: only stages 0..DEPTH-2 are searched. Use this with a
//                write-through register file.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_valid      decode issues an entry into stage 0
//   i_we         issued entry writes the register file
//   i_rw         destination register of the issued entry
//   i_rdy        issued entry's i_data is already valid
//   i_data       data of the issued entry
//   i_stall      decode stall: a bubble enters stage 0
//   i_flush      kill the stage-0 occupant and the issued entry
//   i_upd_en     per-stage result-produced strobe
//   i_upd_data   per-stage produced data, stage k at [k*DATA_W +: DATA_W]
//   i_src_reg    forwarding query registers, query s at [s*REG_W +: REG_W]
//   o_fwd_hit    query s matched a valid in-flight writer
//   o_fwd_data   forwarded value (0 when there is no hit)
//   o_fwd_stall  youngest match for query s is not ready yet
//   o_wb_valid   last stage holds a valid writing entry to a non-zero register
//   o_wb_rw      register-file write address
//   o_wb_data    register-file write data (update-merged)
//   o_occupancy  registered count of valid stages
//
// Issue handshake
//   An entry is accepted into stage 0 at a rising edge when i_valid=1 and
//   i_stall=0 and i_flush=0. While i_stall=1, the issuer holds the same entry
//   and presents it again on a later cycle. A flush discards the presented
//   entry.
// -----------------------------------------------------------------------------
module pipeline_fwd_chain #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    input  logic                         i_we,
    input  logic [REG_W-1:0]             i_rw,
    input  logic                         i_rdy,
    input  logic [DATA_W-1:0]            i_data,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic [DEPTH-1:0]             i_upd_en,
    input  logic [DEPTH*DATA_W-1:0]      i_upd_data,
    input  logic [NUM_SRC*REG_W-1:0]     i_src_reg,
    output logic [NUM_SRC-1:0]           o_fwd_hit,
    output logic [NUM_SRC*DATA_W-1:0]    o_fwd_data,
    output logic [NUM_SRC-1:0]           o_fwd_stall,
    output logic                         o_wb_valid,
    output logic [REG_W-1:0]             o_wb_rw,
    output logic [DATA_W-1:0]            o_wb_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

`ifdef PIPE_FWD_CHAIN_WB_FWD_EN
    localparam int FWD_LAST = DEPTH - 1;
`else
    localparam int FWD_LAST = DEPTH - 2;
`endif

    // ------------------------------------------------------------------
    // Stage storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  we_q;
    logic [DEPTH-1:0]  rdy_q;
    logic [REG_W-1:0]  rw_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [OCC_W-1:0]  occ_q;

    // ------------------------------------------------------------------
    // Update merge
    //   A produced result is visible in the same cycle (forwarding, commit)
    //   and travels on with the entry at the next edge. Strobes on empty
    //   stages are ignored.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]  upd_hit;
    logic [DEPTH-1:0]  rdy_m;
    logic [DATA_W-1:0] data_m [DEPTH];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            upd_hit[k] = valid_q[k] & i_upd_en[k];
            rdy_m[k]   = rdy_q[k] | upd_hit[k];
            data_m[k]  = upd_hit[k] ? i_upd_data[k*DATA_W +: DATA_W] : data_q[k];
        end
    end

    // ------------------------------------------------------------------
    // Next valid vector and its popcount
    //   Stall and flush both gate the issued entry. Flush also kills the
    //   stage-0 occupant as it moves into stage 1.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] valid_d;
    logic [OCC_W-1:0] occ_d;

    always_comb begin
        valid_d    = '0;
        valid_d[0] = i_valid & ~i_stall & ~i_flush;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
        end
        valid_d[1] = valid_q[0] & ~i_flush;

        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    // ------------------------------------------------------------------
    // Chain registers
    //   Non-valid fields load unconditionally. They are don't-care while the
    //   matching valid bit is 0.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            we_q    <= '0;
            rdy_q   <= '0;
            occ_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rw_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            occ_q     <= occ_d;
            we_q[0]   <= i_we;
            rw_q[0]   <= i_rw;
            rdy_q[0]  <= i_rdy;
            data_q[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                we_q[k]   <= we_q[k-1];
                rw_q[k]   <= rw_q[k-1];
                rdy_q[k]  <= rdy_m[k-1];
                data_q[k] <= data_m[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding
    //   The search runs from oldest to youngest, so the youngest match
    //   overwrites any older one. Register 0 never matches.
    // ------------------------------------------------------------------
    always_comb begin
        o_fwd_hit   = '0;
        o_fwd_data  = '0;
        o_fwd_stall = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = FWD_LAST; k >= 0; k--) begin
                if (valid_q[k] && we_q[k] && (rw_q[k] != '0) &&
                    (rw_q[k] == i_src_reg[s*REG_W +: REG_W])) begin
                    o_fwd_hit[s]                  = 1'b1;
                    o_fwd_data[s*DATA_W +: DATA_W] = data_m[k];
                    o_fwd_stall[s]                = ~rdy_m[k];
                end
            end
        end
    end

`ifndef PIPE_FWD_CHAIN_WB_FWD_EN
    // The ready state of the WB stage matters only when WB forwards.
    logic unused_wb_rdy;
    assign unused_wb_rdy = rdy_m[DEPTH-1];
`endif

    // ------------------------------------------------------------------
    // Commit port and occupancy
    // ------------------------------------------------------------------
    assign o_wb_valid  = valid_q[DEPTH-1] & we_q[DEPTH-1] & (rw_q[DEPTH-1] != '0);
    assign o_wb_rw     = rw_q[DEPTH-1];
    assign o_wb_data   = data_m[DEPTH-1];
    assign o_occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_fwd_chain.sv
module tb_pipeline_fwd_chain;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int DEPTH   = 3;
    localparam int NUM_SRC = 2;
    localparam int OCC_W   = $clog2(DEPTH + 1);

    logic                       i_clk;
    logic                       i_rst;
    logic                       i_valid;
    logic                       i_we;
    logic [REG_W-1:0]           i_rw;
    logic                       i_rdy;
    logic [DATA_W-1:0]          i_data;
    logic                       i_stall;
    logic                       i_flush;
    logic [DEPTH-1:0]           i_upd_en;
    logic [DEPTH*DATA_W-1:0]    i_upd_data;
    logic [NUM_SRC*REG_W-1:0]   i_src_reg;
    logic [NUM_SRC-1:0]         o_fwd_hit;
    logic [NUM_SRC*DATA_W-1:0]  o_fwd_data;
    logic [NUM_SRC-1:0]         o_fwd_stall;
    logic                       o_wb_valid;
    logic [REG_W-1:0]           o_wb_rw;
    logic [DATA_W-1:0]          o_wb_data;
    logic [OCC_W-1:0]           o_occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected commits {rw, data}, pushed when issued, popped at WB.
    logic [REG_W+DATA_W-1:0] exp_q[$];

    pipeline_fwd_chain #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .DEPTH  (DEPTH),
        .NUM_SRC(NUM_SRC)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_we       (i_we),
        .i_rw       (i_rw),
        .i_rdy      (i_rdy),
        .i_data     (i_data),
        .i_stall    (i_stall),
        .i_flush    (i_flush),
        .i_upd_en   (i_upd_en),
        .i_upd_data (i_upd_data),
        .i_src_reg  (i_src_reg),
        .o_fwd_hit  (o_fwd_hit),
        .o_fwd_data (o_fwd_data),
        .o_fwd_stall(o_fwd_stall),
        .o_wb_valid (o_wb_valid),
        .o_wb_rw    (o_wb_rw),
        .o_wb_data  (o_wb_data),
        .o_occupancy(o_occupancy)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic we, input logic [REG_W-1:0] rw,
                         input logic rdy, input logic [DATA_W-1:0] data);
        i_valid = 1'b1;
        i_we    = we;
        i_rw    = rw;
        i_rdy   = rdy;
        i_data  = data;
    endtask

    task automatic idle();
        i_valid = 1'b0;
    endtask

    task automatic set_src(input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1);
        i_src_reg = {s1, s0};
    endtask

    task automatic update(input int stage, input logic [DATA_W-1:0] data);
        i_upd_en[stage]                     = 1'b1;
        i_upd_data[stage*DATA_W +: DATA_W]  = data;
    endtask

    task automatic no_update();
        i_upd_en   = '0;
        i_upd_data = '0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_commit(input string tag);
        logic [REG_W+DATA_W-1:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed=commit expected=empty scoreboard", tag);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_valid"}, 64'(o_wb_valid), 64'd1);
            check({tag, "_rw_data"}, 64'({o_wb_rw, o_wb_data}), 64'(exp));
        end
    endtask

    function automatic logic [DATA_W-1:0] fwd_data(input int s);
        return o_fwd_data[s*DATA_W +: DATA_W];
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        i_rst = 1'b0;
        i_valid = 1'b0; i_we = 1'b0; i_rw = '0; i_rdy = 1'b0; i_data = '0;
        i_stall = 1'b0; i_flush = 1'b0;
        i_upd_en = '0; i_upd_data = '0; i_src_reg = '0;

        // 1. Reset overrides an issue, a stall and a flush presented alongside it.
        issue(1'b1, 5'd5, 1'b1, 32'hCAFE);
        i_stall = 1'b1;
        i_flush = 1'b1;
        do_reset();
        idle();
        i_stall = 1'b0;
        i_flush = 1'b0;
        set_src(5'd5, 5'd0);
        settle();
        check("rst_wb_valid",  64'(o_wb_valid),  64'd0);
        check("rst_wb_rw",     64'(o_wb_rw),     64'd0);
        check("rst_wb_data",   64'(o_wb_data),   64'd0);
        check("rst_occupancy", 64'(o_occupancy), 64'd0);
        check("rst_fwd_hit",   64'(o_fwd_hit),   64'd0);
        check("rst_fwd_data",  64'(o_fwd_data),  64'd0);
        check("rst_fwd_stall", 64'(o_fwd_stall), 64'd0);

        // 2. Not-ready producer, then a late update, then commit.
        issue(1'b1, 5'd5, 1'b0, 32'h0505);
        tick();
        idle();
        set_src(5'd5, 5'd7);
        settle();
        check("t2_occ1",        64'(o_occupancy),    64'd1);
        check("t2_hit_pre",     64'(o_fwd_hit[0]),   64'd1);
        check("t2_stall_pre",   64'(o_fwd_stall[0]), 64'd1);
        check("t2_miss_src1",   64'(o_fwd_hit[1]),   64'd0);
        update(0, 32'h1234);
        settle();
        check("t2_hit_upd",     64'(o_fwd_hit[0]),   64'd1);
        check("t2_stall_upd",   64'(o_fwd_stall[0]), 64'd0);
        check("t2_data_upd",    64'(fwd_data(0)),    64'h1234);
        tick();
        no_update();
        settle();
        check("t2_s1_data",     64'(fwd_data(0)),    64'h1234);
        check("t2_s1_stall",    64'(o_fwd_stall[0]), 64'd0);
        check("t2_s1_wb_valid", 64'(o_wb_valid),     64'd0);
        tick();
        check("t2_wb_rw",       64'(o_wb_rw),        64'd5);
        check("t2_wb_data",     64'(o_wb_data),      64'h1234);
`ifdef PIPE_FWD_CHAIN_WB_FWD_EN
        check("t2_wb_fwd_hit",  64'(o_fwd_hit[0]),   64'd1);
`else
        check("t2_wb_fwd_hit",  64'(o_fwd_hit[0]),   64'd0);
`endif
        update(2, 32'h5678);
        exp_q.push_back({5'd5, 32'h5678});
        settle();
        check_commit("t2_commit_merged");
        tick();
        no_update();
        settle();
        check("t2_drained_occ", 64'(o_occupancy), 64'd0);
        check("t2_drained_wb",  64'(o_wb_valid),  64'd0);

        // 3. Load-use: stage-0 producer not ready, then a stall inserts a bubble.
        do_reset();
        issue(1'b1, 5'd8, 1'b0, 32'h0808);
        exp_q.push_back({5'd8, 32'h0808});
        tick();
        issue(1'b1, 5'd9, 1'b1, 32'h0099);
        i_stall = 1'b1;
        set_src(5'd9, 5'd8);
        settle();
        check("t3_lu_hit",    64'(o_fwd_hit[1]),   64'd1);
        check("t3_lu_stall",  64'(o_fwd_stall[1]), 64'd1);
        check("t3_occ_pre",   64'(o_occupancy),    64'd1);
        tick();
        check("t3_occ_stall", 64'(o_occupancy),    64'd1);
        check("t3_bubble",    64'(o_fwd_hit[0]),   64'd0);
        check("t3_s1_stall",  64'(o_fwd_stall[1]), 64'd1);
        i_stall = 1'b0;
        tick();
        idle();
        settle();
        check("t3_occ_after", 64'(o_occupancy),    64'd2);
        check("t3_new_hit",   64'(o_fwd_hit[0]),   64'd1);
        check("t3_new_data",  64'(fwd_data(0)),    64'h0099);
        check("t3_new_stall", 64'(o_fwd_stall[0]), 64'd0);
        check_commit("t3_commit");

        // 4. Youngest match wins.
        do_reset();
        issue(1'b1, 5'd3, 1'b1, 32'hAAAA);
        tick();
        issue(1'b1, 5'd3, 1'b1, 32'hBBBB);
        tick();
        idle();
        set_src(5'd3, 5'd7);
        settle();
        check("t4_occ",       64'(o_occupancy),    64'd2);
        check("t4_hit",       64'(o_fwd_hit),      64'b01);
        check("t4_young",     64'(fwd_data(0)),    64'hBBBB);
        check("t4_miss_data", 64'(fwd_data(1)),    64'd0);
        tick();
        check("t4_young_s12", 64'(fwd_data(0)),    64'hBBBB);

        // 5. Flush together with stall behaves as a flush; register 0 never hits.
        do_reset();
        issue(1'b1, 5'd2, 1'b1, 32'h0022);
        exp_q.push_back({5'd2, 32'h0022});
        tick();
        issue(1'b1, 5'd4, 1'b1, 32'h0044);
        tick();
        issue(1'b1, 5'd6, 1'b1, 32'h0066);
        i_flush = 1'b1;
        i_stall = 1'b1;
        tick();
        i_flush = 1'b0;
        i_stall = 1'b0;
        idle();
        set_src(5'd4, 5'd6);
        settle();
        check("t5_occ",      64'(o_occupancy), 64'd1);
        check("t5_killed",   64'(o_fwd_hit),   64'b00);
        check_commit("t5_commit");
        issue(1'b1, 5'd0, 1'b1, 32'h0077);
        tick();
        idle();
        set_src(5'd0, 5'd0);
        settle();
        check("t5_r0_hit",   64'(o_fwd_hit),   64'b00);
        check("t5_r0_data",  64'(o_fwd_data),  64'd0);
        tick();
        tick();
        check("t5_r0_occ",   64'(o_occupancy), 64'd1);
        check("t5_r0_wb",    64'(o_wb_valid),  64'd0);

        // 6. Producer of r9 reaches WB; WB forwarding depends on the macro.
        do_reset();
        issue(1'b1, 5'd9, 1'b1, 32'h9999);
        exp_q.push_back({5'd9, 32'h9999});
        tick();
        idle();
        set_src(5'd9, 5'd9);
        tick();
        check("t6_s1_hit",   64'(o_fwd_hit),   64'b11);
        tick();
        check_commit("t6_commit");
`ifdef PIPE_FWD_CHAIN_WB_FWD_EN
        check("t6_wb_hit",   64'(o_fwd_hit[0]), 64'd1);
        check("t6_wb_data",  64'(fwd_data(0)),  64'h9999);
`else
        check("t6_wb_hit",   64'(o_fwd_hit[0]), 64'd0);
        check("t6_wb_data",  64'(fwd_data(0)),  64'd0);
`endif

        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
